// File: rtl/walk_pkg.sv
// walk_pkg: shared widths, defaults and channel-index type for the walk-request bank.
package walk_pkg;
    localparam int DEF_NUM_CH          = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 3;
    localparam int DEF_TIMEOUT_CYCLES  = 1000;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width needed to hold the values 0..d.
    function automatic int cnt_w(input int d);
        return (d > 0) ? $clog2(d + 1) : 1;
    endfunction

    typedef logic [ch_w(DEF_NUM_CH)-1:0] ch_idx_t;
endpackage

// File: rtl/walk_debounce.sv
// walk_debounce: one channel of debounce, release arming and sticky request latch.
// WALK_REQ_TIMEOUT_EN adds an age counter that expires an unserviced request.
module walk_debounce
    import walk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef WALK_REQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic clk,
    input  logic global_reset,
    input  logic button,
    input  logic clear,
    output logic pending
`ifdef WALK_REQ_TIMEOUT_EN
    ,
    output logic timeout
`endif
);
    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CHIT = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic armed, hit, kill;

    assign hit = button && cnt == CHIT;

`ifdef WALK_REQ_TIMEOUT_EN
    localparam int AW = cnt_w(TIMEOUT_CYCLES - 1);
    logic [AW-1:0] age;
    logic expire;
    assign expire = pending && age == AW'(TIMEOUT_CYCLES - 1);
    assign kill = clear || expire;
    always_ff @(posedge clk) begin
        if (global_reset) begin
            age     <= '0;
            timeout <= 1'b0;
        end else begin
            age     <= (!pending || kill) ? '0 : age + 1'b1;
            timeout <= expire && !clear;
        end
    end
`else
    assign kill = clear;
`endif

    // A set edge that coincides with a clear still disarms, so the press is consumed.
    always_ff @(posedge clk) begin
        if (global_reset) begin
            cnt     <= '0;
            armed   <= 1'b1;
            pending <= 1'b0;
        end else begin
            cnt     <= !button ? '0 : (cnt == CMAX ? cnt : cnt + 1'b1);
            armed   <= !button ? 1'b1 : (hit ? 1'b0 : armed);
            pending <= kill ? 1'b0 : (pending || (hit && armed));
        end
    end
endmodule

// File: rtl/walk_request_bank.sv
// walk_request_bank: debounced sticky walk requests offered round-robin over valid/ack.
// WALK_REQ_TIMEOUT_EN enables per-channel request expiry with a wr_timeout pulse.
module walk_request_bank
    import walk_pkg::*;
#(
    parameter int NUM_CH          = DEF_NUM_CH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef WALK_REQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                      clk,
    input  logic                      global_reset,
    input  logic [NUM_CH-1:0]         walk_request,
    input  logic [NUM_CH-1:0]         walk_request_reset,
    output logic [NUM_CH-1:0]         wr_to_fsm,
    output logic                      req_valid,
    output logic [ch_w(NUM_CH)-1:0]   req_ch,
    input  logic                      req_ack
`ifdef WALK_REQ_TIMEOUT_EN
    ,
    output logic [NUM_CH-1:0]         wr_timeout
`endif
);
    localparam int CH_W = ch_w(NUM_CH);

    logic [CH_W-1:0]   rr_ptr, idx;
    logic [NUM_CH-1:0] clear;
    logic              take;

    assign req_valid = |wr_to_fsm;
    assign take      = req_ack && req_valid;

    // Scanning downward lets the lowest offset from rr_ptr win.
    always_comb begin
        req_ch = rr_ptr;
        idx    = rr_ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (wr_to_fsm[idx]) req_ch = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (global_reset) rr_ptr <= '0;
        else if (take) rr_ptr <= (int'(req_ch) == NUM_CH - 1) ? '0 : req_ch + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign clear[i] = walk_request_reset[i] || (take && req_ch == CH_W'(i));
        walk_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef WALK_REQ_TIMEOUT_EN
            ,
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
        ) u_db (
            .clk         (clk),
            .global_reset(global_reset),
            .button      (walk_request[i]),
            .clear       (clear[i]),
            .pending     (wr_to_fsm[i])
`ifdef WALK_REQ_TIMEOUT_EN
            ,
            .timeout     (wr_timeout[i])
`endif
        );
    end
endmodule
